// File: rtl/jk_pkg.sv
// Shared JK definitions: operation encoding taken from {j,k} and the
// single-bit next-state function used by every register bit.
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        RESET  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_e;

    function automatic logic jk_next(input jk_op_e op, input logic q);
        logic nxt;
        nxt = q;
        case (op)
            HOLD:    nxt = q;
            RESET:   nxt = 1'b0;
            SET:     nxt = 1'b1;
            TOGGLE:  nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_ff_bit.sv
// Single JK register bit with synchronous active-high reset and clock enable.
// Priority at the edge: rst, then en, then the j/k operation.
module jk_ff_bit
    import jk_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    jk_op_e op;

    assign op = jk_op_e'({j, k});

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= jk_next(op, q);
        end
    end

endmodule

// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops sharing clk, rst and en.
// q_n is a purely combinational complement of the registered state.
module jk_ff
    import jk_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_bit #(
            .RESET_VALUE(RESET_VALUE[i])
        ) u_bit (
            .clk(clk),
            .rst(rst),
            .en (en),
            .j  (j[i]),
            .k  (k[i]),
            .q  (q[i])
        );
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// Bench for jk_ff: three instances (1-bit reset-to-0, 1-bit reset-to-1,
// 4-bit) driven together, with expected states queued at drive time.
module tb_jk_ff;

    logic       clk;
    logic       rst;
    logic       en;
    logic       j1, k1;
    logic       q1, q1_n;
    logic       qr, qr_n;
    logic [3:0] j4, k4;
    logic [3:0] q4, q4_n;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp1_q[$];
    logic [3:0] expr_q[$];
    logic [3:0] exp4_q[$];

    logic       m1, mr;
    logic [3:0] m4;

    jk_ff #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .j(j1), .k(k1), .q(q1), .q_n(q1_n)
    );

    jk_ff #(.WIDTH(1), .RESET_VALUE(1'b1)) dut_rv (
        .clk(clk), .rst(rst), .en(en), .j(1'b1), .k(1'b1), .q(qr), .q_n(qr_n)
    );

    jk_ff #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .j(j4), .k(k4), .q(q4), .q_n(q4_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one JK bit written straight from the truth table
    function automatic logic model_bit(input logic jj, input logic kk, input logic cur);
        if (jj && !kk)      return 1'b1;
        else if (!jj && kk) return 1'b0;
        else if (jj && kk)  return ~cur;
        else                return cur;
    endfunction

    task automatic step(input logic r, input logic e, input logic jj1, input logic kk1,
                        input logic [3:0] jj4, input logic [3:0] kk4, input string tag);
        logic [3:0] e1, er, e4;
        @(negedge clk);
        rst = r; en = e; j1 = jj1; k1 = kk1; j4 = jj4; k4 = kk4;
        if (r) begin
            m1 = 1'b0; mr = 1'b1; m4 = 4'b0000;
        end else if (e) begin
            m1 = model_bit(jj1, kk1, m1);
            mr = model_bit(1'b1, 1'b1, mr);
            for (int b = 0; b < 4; b++) m4[b] = model_bit(jj4[b], kk4[b], m4[b]);
        end
        exp1_q.push_back({3'b000, m1});
        expr_q.push_back({3'b000, mr});
        exp4_q.push_back(m4);
        @(posedge clk);
        #1;
        if (exp1_q.size() == 0 || expr_q.size() == 0 || exp4_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e1 = exp1_q.pop_front();
            er = expr_q.pop_front();
            e4 = exp4_q.pop_front();
            check({tag, " q1"},   {3'b000, q1},   e1);
            check({tag, " q1_n"}, {3'b000, q1_n}, {3'b000, ~e1[0]});
            check({tag, " qr"},   {3'b000, qr},   er);
            check({tag, " qr_n"}, {3'b000, qr_n}, {3'b000, ~er[0]});
            check({tag, " q4"},   q4,             e4);
            check({tag, " q4_n"}, q4_n,           ~e4);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; j1 = 1'b0; k1 = 1'b0; j4 = '0; k4 = '0;
        m1 = 1'bx; mr = 1'bx; m4 = 'x;

        // reset overrides j=k=1
        step(1, 1, 1, 1, 4'hF, 4'hF, "rst0");
        step(1, 1, 1, 1, 4'hF, 4'hF, "rst1");

        // truth table on dut1, multi-bit pattern on dut4
        step(0, 1, 0, 0, 4'b1010, 4'b0110, "hold0");
        step(0, 1, 0, 0, 4'b1010, 4'b0110, "hold1");
        step(0, 1, 0, 1, 4'b0000, 4'b0000, "clr0");
        step(0, 1, 0, 1, 4'b0000, 4'b0000, "clr1");
        step(0, 1, 1, 0, 4'b0101, 4'b0000, "set0");
        step(0, 1, 1, 0, 4'b0101, 4'b0000, "set1");
        step(0, 1, 1, 1, 4'b1111, 4'b1111, "tgl0");
        step(0, 1, 1, 1, 4'b1111, 4'b1111, "tgl1");

        // continuous toggle from q=0
        step(0, 1, 0, 1, 4'b0000, 4'b1111, "pre_tgl");
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 4'b1100, 4'b1100, "ctgl");

        // enable gating with q=1
        step(0, 1, 1, 0, 4'b1111, 4'b0000, "pre_en");
        step(0, 0, 0, 1, 4'b0000, 4'b1111, "en_off0");
        step(0, 0, 1, 1, 4'b1111, 4'b1111, "en_off1");
        step(0, 0, 0, 1, 4'b0000, 4'b1111, "en_off2");
        step(0, 1, 0, 1, 4'b0000, 4'b1111, "en_on");

        // reset mid-toggle while q=1, then resume toggling
        step(0, 1, 1, 1, 4'b1111, 4'b1111, "mid_tgl");
        step(1, 1, 1, 1, 4'b1111, 4'b1111, "mid_rst");
        step(0, 1, 1, 1, 4'b1111, 4'b1111, "mid_resume");

        // random traffic
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
